dmem_image_streamer: RTL and testbench
======================================

Name: dmem_image_streamer

Overview:
- Bus initiator that reads a processed image back out of the data memory, instead of dumping it to a file.
- After the pipeline finishes, the streamer takes the dmem address port, issues sequential word reads from BASE, and absorbs the fixed RAM read latency.
- Words are delivered on a valid/ready stream to a downstream sink such as a UART or VGA formatter.
- A small credit-checked skid FIFO guarantees no read is issued that cannot be stored.

Parameters:
- ADDR_W, 32, width of the dmem address.
- DATA_W, 32, width of a dmem word.
- IMG_WORDS, 129600, number of words per image (360x360, one pixel per word).
- RD_LAT, 1, rising edges from address presented to rd valid at the RAM output.
- FIFO_DEPTH, 4, skid FIFO entries; must be at least RD_LAT+1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse that begins a transfer; ignored unless idle.
- base_addr  in  ADDR_W  first word address, sampled on the start pulse.
- mem_req  out  1  bus ownership request; the top-level mux gives the dmem address port to the streamer while high.
- mem_gnt  in  1  grant from the top-level arbiter.
- mem_addr  out  ADDR_W  read address driven to dmem.
- mem_we  out  1  tied 0; the streamer never writes.
- mem_rd  in  DATA_W  read data from dmem.
- m_data  out  DATA_W  stream word.
- m_valid  out  1  stream word valid.
- m_ready  in  1  sink accepts the word.
- m_last  out  1  asserted with the final word (index IMG_WORDS-1).
- busy  out  1  high from start until the last word is accepted.
- done  out  1  one-cycle pulse when the last word is accepted.

Behaviour:
- Reset values: mem_req=0, mem_addr=0, mem_we=0, m_valid=0, m_last=0, busy=0, done=0. FIFO is empty and all counters are 0.
- FSM states:
  - IDLE: on start, latch base_addr, clear the issue and delivery counters, set busy and mem_req, go to REQ.
  - REQ: wait for mem_gnt, then go to FETCH.
  - FETCH: issue one read per cycle while mem_gnt=1, issue_cnt<IMG_WORDS, and credits>0. When issue_cnt reaches IMG_WORDS, drop mem_req and go to DRAIN.
  - DRAIN: wait until the FIFO is empty, the last word has been accepted, and no read is in flight; then pulse done, clear busy, go to IDLE.
- Issue: mem_addr = base + issue_cnt, where the sum is ADDR_W bits and wraps modulo 2^ADDR_W with no error. Each issue pushes a token into an RD_LAT-deep shift register. The token emerging from it writes mem_rd into the FIFO on that same edge.
- Credits: credits = FIFO_DEPTH - fifo_count - inflight. A read is issued only if credits>0, so FIFO overflow is impossible by construction.
- Grant loss: if mem_gnt drops during FETCH, issuing stops immediately and the address is held. Reads already in flight still land in the FIFO. Issuing resumes on re-grant with no skipped or repeated word.
- Stream side: m_valid = FIFO non-empty. m_data is the FIFO head and must stay stable while m_valid=1 and m_ready=0. A word transfers when m_valid and m_ready are both 1. m_last is high when deliver_cnt == IMG_WORDS-1.
- Simultaneous push and pop on the same edge is legal at any occupancy, including full and empty.
- Throughput: with mem_gnt=1 and m_ready=1 held, one word per cycle. First m_valid appears RD_LAT+1 cycles after the grant is seen in REQ.
- start while busy: ignored, with no change to counters or the address.
- Asynchronous reset mid-transfer returns everything to reset values at once. The partial image is discarded and in-flight tokens are cleared.
- RAM edge case: addresses the RAM treats as out of range return 0. The streamer passes those 0 words through unchanged.

Decomposition:
- Package dmem_stream_pkg holds:
  - the state enum {IDLE, REQ, FETCH, DRAIN};
  - localparams IMG_W=360, IMG_H=360, IMG_WORDS=IMG_W*IMG_H;
  - the DMEM_DEPTH constant shared with the RAM.
- One sub-module, stream_fifo: parameterised depth and width, synchronous FIFO with count output, first-word-fall-through head, async active-low reset.

Test Plan:
- Basic run: IMG_WORDS=8 (override), RAM preloaded with address value, base 0x10, gnt=1, m_ready=1 -> words 0x10..0x17 delivered on consecutive cycles; m_last only on 0x17; done one cycle after; busy low afterwards.
- Backpressure: m_ready toggles 1,0,0,1 repeatedly -> no loss or duplication, m_data stable while stalled, at most FIFO_DEPTH reads outstanding plus buffered, mem_addr holds while credits=0.
- Grant loss: deassert mem_gnt for 3 cycles after the 3rd issue -> mem_addr frozen at base+3, in-flight word still delivered, full sequence intact.
- Wrap: base_addr=0xFFFFFFFE, IMG_WORDS=4 -> addresses FFFFFFFE, FFFFFFFF, 0, 1 are issued.
- Ignored start plus reset: pulse start mid-transfer -> no effect. Assert rst_n=0 during FETCH -> all outputs 0 immediately; a fresh start then delivers from word 0.
- Full image: IMG_WORDS=129600, random m_ready -> exactly 129600 words accepted, checksum matches RAM contents, exactly one done pulse.

Source files
------------

// File: rtl/dmem_image_streamer_pkg.sv
// Shared types and image constants for the dmem image streamer.
package dmem_stream_pkg;

  // Streamer control states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    FETCH = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // Processed image geometry, one pixel per dmem word.
  localparam int IMG_W     = 360;
  localparam int IMG_H     = 360;
  localparam int IMG_WORDS = IMG_W * IMG_H;

  // Number of words the data memory decodes; addresses at or above read as 0.
  localparam int DMEM_DEPTH = 131072;

endpackage

// File: rtl/dmem_image_streamer_if.sv
// Bus bundle of the streamer: dmem read port plus the outbound word stream.
interface dmem_image_streamer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              mem_req;
  logic              mem_gnt;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_rd;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  // Streamer side: owns the request, address and stream outputs.
  modport master (
    output mem_req, mem_addr, mem_we, m_data, m_valid, m_last,
    input  mem_gnt, mem_rd, m_ready
  );

  // Environment side: arbiter, memory and stream sink.
  modport slave (
    input  mem_req, mem_addr, mem_we, m_data, m_valid, m_last,
    output mem_gnt, mem_rd, m_ready
  );
endinterface

// File: rtl/dmem_image_streamer_fifo.sv
// Small synchronous skid FIFO with first-word-fall-through head and occupancy count.
module stream_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // A push into a full FIFO is accepted only when a pop frees the slot on the same edge.
  assign do_pop  = pop && (count_reg != '0);
  assign do_push = push && ((count_reg != CNT_W'(DEPTH)) || do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= ptr_inc(wr_ptr_reg);
      if (do_pop)  rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage write; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);
endmodule

// File: rtl/dmem_image_streamer.sv
// Reads an image out of dmem with sequential word reads and streams it on valid/ready.
module dmem_image_streamer #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int IMG_WORDS  = dmem_stream_pkg::IMG_WORDS,
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4   // must cover RD_LAT+1 for full throughput
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  dmem_image_streamer_if.master bus,
  output logic                  busy,
  output logic                  done
);
  import dmem_stream_pkg::*;

  localparam int CNT_W  = $clog2(IMG_WORDS + 1);
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int LAT_W  = $clog2(RD_LAT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(IMG_WORDS - 1);
  localparam logic [CNT_W-1:0] ALL_WORDS = CNT_W'(IMG_WORDS);

  state_t              state_reg;
  state_t              state_next;
  logic [ADDR_W-1:0]   base_reg;
  logic [CNT_W-1:0]    issue_cnt_reg;
  logic [CNT_W-1:0]    deliver_cnt_reg;
  logic [RD_LAT-1:0]   tok_reg;
  logic [LAT_W-1:0]    inflight;
  logic [FCNT_W-1:0]   fifo_count;
  logic                fifo_empty;
  logic [DATA_W-1:0]   fifo_head;
  logic                issue;
  logic                push;
  logic                pop;
  logic                credit_ok;
  logic                start_accept;

  assign start_accept = (state_reg == IDLE) && start;
  // The oldest token marks the cycle in which mem_rd carries the matching word.
  assign push = tok_reg[RD_LAT-1];
  assign pop  = !fifo_empty && bus.m_ready;
  // Every issued read already owns a FIFO slot, so a landing word can never overflow.
  assign credit_ok = (int'(fifo_count) + int'(inflight)) < FIFO_DEPTH;

  // Number of reads issued whose data has not yet reached the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) begin
      inflight = inflight + LAT_W'(tok_reg[i]);
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Next-state, read issue and completion pulse.
  always_comb begin
    state_next = state_reg;
    issue      = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) state_next = REQ;
      end
      REQ: begin
        if (bus.mem_gnt) state_next = FETCH;
      end
      FETCH: begin
        issue = bus.mem_gnt && (issue_cnt_reg < ALL_WORDS) && credit_ok;
        if ((issue && (issue_cnt_reg == LAST_IDX)) || (issue_cnt_reg >= ALL_WORDS)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_empty && (deliver_cnt_reg == ALL_WORDS) && (inflight == '0)) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Base latch plus issue and delivery counters; a start while busy never reaches here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_reg        <= '0;
      issue_cnt_reg   <= '0;
      deliver_cnt_reg <= '0;
    end else if (start_accept) begin
      base_reg        <= base_addr;
      issue_cnt_reg   <= '0;
      deliver_cnt_reg <= '0;
    end else begin
      if (issue) issue_cnt_reg   <= issue_cnt_reg + 1'b1;
      if (pop)   deliver_cnt_reg <= deliver_cnt_reg + 1'b1;
    end
  end

  // Read-latency token pipeline, one stage per RAM latency edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tok_reg <= '0;
    end else begin
      tok_reg[0] <= issue;
      for (int i = 1; i < RD_LAT; i++) begin
        tok_reg[i] <= tok_reg[i-1];
      end
    end
  end

  stream_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (bus.mem_rd),
    .pop       (pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty)
  );

  // Address is base plus words issued, wrapping naturally in ADDR_W bits;
  // it holds whenever issue stalls on grant or credit.
  assign bus.mem_addr = base_reg + ADDR_W'(issue_cnt_reg);
  assign bus.mem_req  = (state_reg == REQ) || (state_reg == FETCH);
  assign bus.mem_we   = 1'b0;
  assign bus.m_data   = fifo_head;
  assign bus.m_valid  = !fifo_empty;
  assign bus.m_last   = !fifo_empty && (deliver_cnt_reg == LAST_IDX);
  assign busy         = (state_reg != IDLE);
endmodule

// File: tb/tb_dmem_image_streamer.sv
// Directed bench for dmem_image_streamer with an 8-word image and a 1-cycle RAM model.
module tb_dmem_image_streamer;
  import dmem_stream_pkg::*;

  localparam int N  = 8;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic          busy;
  logic          done;

  dmem_image_streamer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_image_streamer #(
    .ADDR_W(AW), .DATA_W(DW), .IMG_WORDS(N), .RD_LAT(1), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
    .bus(bus), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // RAM contents: each in-range word holds its own address, out of range reads 0.
  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (a < 32'(DMEM_DEPTH)) ? a : 32'h0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) bus.mem_rd <= ram_word(bus.mem_addr);

  logic [31:0] cur_base = '0;
  int          acc_idx = 0;
  int          done_cnt = 0;
  int          first_valid_cyc = -1;
  int          first_acc_cyc = -1;
  int          last_acc_cyc = -1;
  int          done_cyc = -1;
  int          run_start_cyc = 0;
  bit          gnt_dropped = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data = '0;
  logic [31:0] addr_log[$];

  // Stream scoreboard and bus monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.mem_req) begin
        if (addr_log.size() == 0 || addr_log[$] != bus.mem_addr) addr_log.push_back(bus.mem_addr);
        check("outstanding", (int'(bus.mem_addr - cur_base) - acc_idx) <= 4, 1);
      end
      if (bus.m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stall_prev) begin
        check("stall_valid", bus.m_valid, 1);
        check("stall_data", bus.m_data, stall_data);
      end
      if (bus.m_valid && bus.m_ready) begin
        check("data", bus.m_data, ram_word(cur_base + 32'(acc_idx)));
        check("last", bus.m_last, acc_idx == N - 1);
        if (acc_idx == 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
        acc_idx++;
      end
      stall_prev = bus.m_valid && !bus.m_ready;
      stall_data = bus.m_data;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      check("mem_we", bus.mem_we, 0);
    end
  end

  task automatic begin_run(input logic [31:0] base);
    cur_base = base;
    acc_idx = 0;
    done_cnt = 0;
    first_valid_cyc = -1;
    first_acc_cyc = -1;
    last_acc_cyc = -1;
    done_cyc = -1;
    stall_prev = 1'b0;
    gnt_dropped = 0;
    addr_log.delete();
    @(posedge clk); #1;
    base_addr = base;
    start = 1'b1;
    run_start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = 32'hDEAD_0000;
  endtask

  // rmode: 0 ready held high, 1 ready pattern 1,0,0,1, 2 random ready.
  task automatic run_image(input logic [31:0] base, input int rmode, input bit gnt_drop,
                           input bit extra_start, input string tag);
    int hold = 0;
    bit fin = 0;
    bus.m_ready = 1'b1;
    begin_run(base);
    for (int t = 0; t < 400 && !fin; t++) begin
      case (rmode)
        0:       bus.m_ready = 1'b1;
        1:       bus.m_ready = (t % 4 == 0) || (t % 4 == 3);
        default: bus.m_ready = 1'($urandom_range(0, 1));
      endcase
      if (extra_start && t == 4) begin
        start = 1'b1;
        base_addr = 32'h0000_0099;
      end else begin
        start = 1'b0;
      end
      if (gnt_drop) begin
        if (hold > 0) begin
          hold--;
          check({tag, "_hold_addr"}, bus.mem_addr, base + 32'd3);
          check({tag, "_hold_req"}, bus.mem_req, 1);
          if (hold == 0) bus.mem_gnt = 1'b1;
        end else if (!gnt_dropped && bus.mem_addr == base + 32'd3) begin
          gnt_dropped = 1;
          bus.mem_gnt = 1'b0;
          hold = 3;
        end
      end
      @(posedge clk); #1;
      if (done_cnt > 0 && !busy) fin = 1;
    end
    start = 1'b0;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_finished"}, fin, 1);
    check({tag, "_words"}, acc_idx, N);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_done_timing"}, done_cyc, last_acc_cyc + 1);
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_addr_count"}, addr_log.size(), N);
    for (int i = 0; i < N && i < addr_log.size(); i++) begin
      check({tag, "_addr"}, addr_log[i], base + 32'(i));
    end
  endtask

  initial begin
    bus.mem_gnt = 1'b1;
    bus.m_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;

    run_image(32'h0000_0010, 0, 0, 0, "basic");
    check("basic_first_valid", first_valid_cyc - run_start_cyc, 4);
    check("basic_first_acc", first_acc_cyc, first_valid_cyc);
    check("basic_consecutive", last_acc_cyc - first_acc_cyc, N - 1);

    run_image(32'h0000_0030, 1, 0, 0, "backpressure");

    run_image(32'h0000_0050, 0, 1, 0, "gnt_loss");
    check("gnt_loss_dropped", gnt_dropped, 1);

    run_image(32'hFFFF_FFFE, 0, 0, 0, "wrap");

    run_image(32'h0000_0040, 2, 0, 1, "ign_start");

    // Reset in the middle of FETCH, then a fresh transfer from word 0.
    begin
      bit seen = 0;
      bus.m_ready = 1'b1;
      begin_run(32'h0000_0020);
      for (int t = 0; t < 50 && !seen; t++) begin
        if (bus.mem_addr == 32'h0000_0022) seen = 1;
        else begin
          @(posedge clk); #1;
        end
      end
      check("rst_mid_reached_fetch", seen, 1);
      rst_n = 1'b0;
      #1;
      check("rst_mid_mem_req", bus.mem_req, 0);
      check("rst_mid_mem_addr", bus.mem_addr, 0);
      check("rst_mid_m_valid", bus.m_valid, 0);
      check("rst_mid_m_last", bus.m_last, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_hold_m_valid", bus.m_valid, 0);
      check("rst_hold_mem_req", bus.mem_req, 0);
      rst_n = 1'b1;
    end
    run_image(32'h0000_0020, 2, 0, 0, "after_rst");

    for (int r = 0; r < 3; r++) begin
      run_image(32'(r * 32'h100 + 5), 2, 0, 0, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
